fft_frame_loader: RTL and testbench

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_frame_bank.sv | 32 +++
 rtl/fft_frame_loader.sv | 115 +++++++++++
 tb/tb_fft_frame_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame loader.
// No logic; widths, frame size, read-side FSM states and Q8.8 coefficients.
package fft_pkg;

    localparam int DW    = 16;
    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } rd_state_t;

    // Q8.8 signed fixed-point constants
    localparam logic [DW-1:0] Q_ONE    = 16'h0100;
    localparam logic [DW-1:0] Q_RSQRT2 = 16'h00B5;

endpackage

// File: rtl/fft_frame_bank.sv
// Purpose: one frame bank of N complex samples, written one sample per cycle by index.
// Latency: a write is visible on rd_real/rd_imag the cycle after the write edge.
// Backpressure: none; the owner must not write while the bank is being consumed.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int BW = fft_pkg::DW,
    parameter int BN = fft_pkg::N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [$clog2(BN)-1:0]  idx,
    input  logic signed [BW-1:0]   wr_real,
    input  logic signed [BW-1:0]   wr_imag,
    output logic signed [BW-1:0]   rd_real [0:BN-1],
    output logic signed [BW-1:0]   rd_imag [0:BN-1]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BN; i++) begin
                rd_real[i] <= '0;
                rd_imag[i] <= '0;
            end
        end else if (we) begin
            rd_real[idx] <= wr_real;
            rd_imag[idx] <= wr_imag;
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Purpose: ping-pong loader collecting 8-sample complex frames and handing them to an FFT.
// Latency: start pulses one cycle after the last sample of a frame is accepted (FFT idle).
// Backpressure: in_ready falls only while the bank being written is still full.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int DW = fft_pkg::DW,
    parameter int N  = fft_pkg::N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    output logic signed [DW-1:0] x_real [0:N-1],
    output logic signed [DW-1:0] x_imag [0:N-1],
    output logic                 start,
    input  logic                 fft_done,
    output logic [7:0]           frame_cnt
);

    localparam int IW = $clog2(N);

    logic          wr_bank;
    logic [IW-1:0] wr_idx;
    logic [1:0]    bank_full;
    logic          rd_bank;
    rd_state_t     state;

    logic          accept;
    logic          release_bank;
    logic [1:0]    set_mask;
    logic [1:0]    clr_mask;

    logic signed [DW-1:0] b0_real [0:N-1];
    logic signed [DW-1:0] b0_imag [0:N-1];
    logic signed [DW-1:0] b1_real [0:N-1];
    logic signed [DW-1:0] b1_imag [0:N-1];

    assign in_ready     = !bank_full[wr_bank];
    assign accept       = in_valid && in_ready;
    assign release_bank = (state == S_BUSY) && fft_done;
    assign start        = (state == S_START);

    // Set and clear always target different banks: a full bank is never written.
    assign set_mask = (accept && wr_idx == IW'(N-1)) ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask = release_bank ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            bank_full <= 2'b00;
        end else begin
            if (accept) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == IW'(N-1))
                    wr_bank <= ~wr_bank;
            end
            bank_full <= (bank_full | set_mask) & ~clr_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_bank   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE:  if (bank_full[rd_bank]) state <= S_START;
                S_START: state <= S_BUSY;
                S_BUSY: begin
                    if (fft_done) begin
                        state     <= S_IDLE;
                        rd_bank   <= ~rd_bank;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fft_frame_bank #(.BW(DW), .BN(N)) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept && !wr_bank),
        .idx     (wr_idx),
        .wr_real (in_real),
        .wr_imag (in_imag),
        .rd_real (b0_real),
        .rd_imag (b0_imag)
    );

    fft_frame_bank #(.BW(DW), .BN(N)) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept && wr_bank),
        .idx     (wr_idx),
        .wr_real (in_real),
        .wr_imag (in_imag),
        .rd_real (b1_real),
        .rd_imag (b1_imag)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            x_real[i] = rd_bank ? b1_real[i] : b0_real[i];
            x_imag[i] = rd_bank ? b1_imag[i] : b0_imag[i];
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with a simple FFT completion model.
module tb_fft_frame_loader;
    import fft_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [15:0]   in_real = '0;
    logic signed [15:0]   in_imag = '0;
    logic signed [15:0]   x_real [0:7];
    logic signed [15:0]   x_imag [0:7];
    logic                 start;
    logic                 fft_done;
    logic [7:0]           frame_cnt;

    logic model_done  = 1'b0;
    logic manual_done = 1'b0;
    assign fft_done = model_done | manual_done;

    int checks = 0;
    int errors = 0;

    int          n_starts = 0;
    int          busy_cnt = 0;
    int          stall_cnt = 0;
    bit          auto_fft = 1'b1;
    int          fft_lat = 5;
    logic [15:0] cap_re [$];
    logic [15:0] cap_im [$];
    logic [15:0] exp_re [$];
    logic [15:0] exp_im [$];
    logic [15:0] sine [8];

    fft_frame_loader #(.DW(16), .N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .x_real    (x_real),
        .x_imag    (x_imag),
        .start     (start),
        .fft_done  (fft_done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // FFT model and frame capture, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            n_starts   = 0;
            busy_cnt   = 0;
            stall_cnt  = 0;
            model_done = 1'b0;
            cap_re.delete();
            cap_im.delete();
        end else begin
            model_done = 1'b0;
            if (in_valid && !in_ready) stall_cnt++;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) model_done = 1'b1;
            end
            if (start) begin
                n_starts++;
                for (int i = 0; i < 8; i++) begin
                    cap_re.push_back(x_real[i]);
                    cap_im.push_back(x_imag[i]);
                end
                if (auto_fft) busy_cnt = fft_lat;
            end
        end
    end

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        manual_done = 1'b0;
        exp_re.delete();
        exp_im.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] r, input logic [15:0] im, input logic d);
        int guard = 0;
        in_valid    = 1'b1;
        in_real     = r;
        in_imag     = im;
        manual_done = d;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_ready", {15'b0, in_ready}, 16'h0001);
            in_valid    = 1'b0;
            manual_done = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        exp_re.push_back(r);
        exp_im.push_back(im);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        manual_done = 1'b0;
    endtask

    task automatic wait_cnt(input int n, input string tag);
        int g = 0;
        while (frame_cnt != 8'(n) && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(tag, {8'b0, frame_cnt}, 16'(n));
    endtask

    task automatic pulse_done();
        manual_done = 1'b1;
        @(posedge clk);
        #1 manual_done = 1'b0;
    endtask

    task automatic check_frames(input string tag, input int nexp);
        check({tag, "_starts"}, 16'(n_starts), 16'(nexp));
        for (int k = 0; k < exp_re.size(); k++) begin
            if (k < cap_re.size()) begin
                check($sformatf("%s_re%0d", tag, k), cap_re[k], exp_re[k]);
                check($sformatf("%s_im%0d", tag, k), cap_im[k], exp_im[k]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sine = '{16'h0000, Q_RSQRT2, Q_ONE, Q_RSQRT2, 16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", {15'b0, start}, 16'h0000);
        check("rst_frame_cnt", {8'b0, frame_cnt}, 16'h0000);
        check("rst_x_real0", x_real[0], 16'h0000);
        check("rst_x_imag7", x_imag[7], 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {15'b0, in_ready}, 16'h0001);

        // Impulse frame and start latency
        for (int i = 0; i < 8; i++)
            send((i == 0) ? Q_ONE : 16'h0000, 16'h0000, 1'b0);
        check("imp_start_e", {15'b0, start}, 16'h0000);
        @(posedge clk);
        #1;
        check("imp_start_e1", {15'b0, start}, 16'h0001);
        check("imp_x0", x_real[0], 16'h0100);
        for (int i = 1; i < 8; i++)
            check($sformatf("imp_x%0d", i), x_real[i], 16'h0000);
        @(posedge clk);
        #1;
        check("imp_start_e2", {15'b0, start}, 16'h0000);
        wait_cnt(1, "imp_frame_cnt");
        check_frames("imp", 1);

        // Sine frame
        do_reset();
        for (int i = 0; i < 8; i++)
            send(sine[i], 16'h0000, 1'b0);
        wait_cnt(1, "sine_frame_cnt");
        check_frames("sine", 1);

        // 24 back-to-back samples, 5-cycle FFT: never two full banks
        do_reset();
        for (int i = 0; i < 24; i++)
            send(16'(16 * i + 1), 16'(-i), 1'b0);
        wait_cnt(3, "stream_frame_cnt");
        check("stream_stalls", 16'(stall_cnt), 16'h0000);
        check_frames("stream", 3);

        // Both banks full with the FFT held busy
        do_reset();
        auto_fft = 1'b0;
        for (int i = 0; i < 16; i++)
            send(16'(16'h0200 + i), 16'(16'h0300 + i), 1'b0);
        check("full_in_ready", {15'b0, in_ready}, 16'h0000);
        in_valid = 1'b1;
        in_real  = 16'h7777;
        in_imag  = 16'h7777;
        repeat (3) @(posedge clk);
        #1;
        check("full_hold_ready", {15'b0, in_ready}, 16'h0000);
        in_valid = 1'b0;
        check("full_starts", 16'(n_starts), 16'h0001);
        pulse_done();
        check("full_rel_cnt", {8'b0, frame_cnt}, 16'h0001);
        check("full_rel_ready", {15'b0, in_ready}, 16'h0001);
        @(posedge clk);
        #1;
        check("full_start2", {15'b0, start}, 16'h0001);
        for (int i = 0; i < 8; i++)
            send(16'(16'h0400 + i), 16'(16'h0500 + i), 1'b0);
        pulse_done();
        repeat (3) @(posedge clk);
        #1;
        pulse_done();
        check("full_frame_cnt", {8'b0, frame_cnt}, 16'h0003);
        check_frames("full", 3);

        // Spurious done in idle, then done coinciding with a bank fill
        do_reset();
        pulse_done();
        check("spur_idle_cnt", {8'b0, frame_cnt}, 16'h0000);
        for (int i = 0; i < 8; i++)
            send(16'(16'h0600 + i), 16'(16'h0010 + i), (i == 7));
        check("spur_fill_cnt", {8'b0, frame_cnt}, 16'h0000);
        @(posedge clk);
        #1;
        check("spur_start", {15'b0, start}, 16'h0001);
        for (int i = 0; i < 8; i++)
            send(16'(16'h0700 + i), 16'(16'h0020 + i), (i == 7));
        check("simul_cnt", {8'b0, frame_cnt}, 16'h0001);
        check("simul_ready", {15'b0, in_ready}, 16'h0001);
        @(posedge clk);
        #1;
        check("simul_start", {15'b0, start}, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        pulse_done();
        check("simul_frame_cnt", {8'b0, frame_cnt}, 16'h0002);
        check_frames("simul", 2);

        // Reset in the middle of a frame
        do_reset();
        auto_fft = 1'b1;
        for (int i = 0; i < 5; i++)
            send(16'(16'h0A00 + i), 16'(16'h0B00 + i), 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++)
            check($sformatf("mid_rst_x%0d", i), x_real[i], 16'h0000);
        for (int i = 0; i < 8; i++)
            send(16'(16'h0C00 + i), 16'(16'h0D00 + i), 1'b0);
        wait_cnt(1, "mid_rst_frame_cnt");
        repeat (10) @(posedge clk);
        #1;
        check_frames("mid_rst", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
